uart_rx_deserializer: RTL and testbench

UART receive front end for the debug unit. It samples the asynchronous `i_rx` serial line with 16× oversampling using an internal baud tick and deserializes 8N1 frames LSB first. Each completed byte is presented with a one-cycle `o_rx_done` strobe, which is the write pulse for the receive FIFO inside the UART top. Framing errors are flagged, and a held-low line (break) is absorbed so that it does not produce a stream of bogus bytes.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/uart_rx_deserializer.sv | 152 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

  // Receiver FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Oversample ticks per bit, and the tick index that lands mid start bit.
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Default frame and baud settings.
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int DVSR_DEFAULT    = 326;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running baud divider: one-clock tick every DVSR clocks.
// The tick is registered; it is high while the count sits at DVSR-1.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DVSR   = DVSR_DEFAULT,
  parameter int DVSR_W = 9
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] count_r;
  logic              tick_r;

  // Count 0..DVSR-1 and wrap; tick_r is precomputed so it equals (count_r == LAST).
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      count_r <= '0;
      tick_r  <= (LAST == '0);
    end else if (count_r == LAST) begin
      count_r <= '0;
      tick_r  <= (LAST == '0);
    end else begin
      count_r <= count_r + DVSR_W'(1);
      tick_r  <= ((count_r + DVSR_W'(1)) == LAST);
    end
  end

  assign o_tick = tick_r;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversampled 8N1 deserializer with framing
// error flag and break absorption. One-cycle o_rx_done per received byte.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT,
  parameter int DVSR    = DVSR_DEFAULT,
  parameter int DVSR_W  = 9
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int             N_W    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
  localparam logic [3:0]     MID_S  = 4'(MID_TICK);
  localparam logic [3:0]     BIT_S  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     STOP_S = 4'(SB_TICK - 1);

  logic            rx_sync1_r;
  logic            rx_sync2_r;
  logic            rx_s;
  logic            tick_s;
  rx_state_t       state_r;
  logic [3:0]      s_r;
  logic [N_W-1:0]  n_r;
  logic [DBIT-1:0] b_r;
  logic [DBIT-1:0] data_r;
  logic            done_r;
  logic            ferr_r;
  logic            busy_r;

  baud_tick_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick_s)
  );

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
    end else begin
      rx_sync1_r <= i_rx;
      rx_sync2_r <= rx_sync1_r;
    end
  end

  assign rx_s = rx_sync2_r;

  // Frame FSM: start qualification, mid-bit data sampling, stop check, break hold.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_r <= IDLE;
      s_r     <= 4'd0;
      n_r     <= '0;
      b_r     <= '0;
      data_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ferr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            s_r     <= 4'd0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            if (s_r == MID_S) begin
              if (!rx_s) begin
                state_r <= DATA;
                s_r     <= 4'd0;
                n_r     <= '0;
              end else begin
                // Line went back high before mid start bit: glitch.
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (s_r == BIT_S) begin
              s_r <= 4'd0;
              b_r <= {rx_s, b_r[DBIT-1:1]};
              if (n_r == N_LAST) begin
                state_r <= STOP;
              end else begin
                n_r <= n_r + N_W'(1);
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (s_r == STOP_S) begin
              data_r <= b_r;
              done_r <= 1'b1;
              ferr_r <= ~rx_s;
              if (rx_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                // Stop bit low: wait out the held-low line before listening again.
                state_r <= BREAK;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_r;
  assign o_rx_done   = done_r;
  assign o_frame_err = ferr_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer with DVSR=4 (64 clocks/bit).
// Expected bytes come from the frames the bench itself sends: a queue of
// {byte, stop bit low} records consumed by a strobe monitor.
module tb_uart_rx_deserializer;

  localparam int DVSR     = 4;
  localparam int BIT_CLKS = 16 * DVSR;
  // Strobe edge count after driving the start edge: 2 sync flops + 1 clock
  // for IDLE to react, first tick 1..DVSR clocks later, then 151 more ticks.
  localparam int LAT_LO   = 3 + 151 * DVSR + 1;
  localparam int LAT_HI   = 3 + 151 * DVSR + DVSR;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  int         vectors;
  int         miscompares;
  exp_t       exp_q[$];
  logic [7:0] model_data;
  logic       rst_q;
  bit         armed;
  bit         ferr_leak;
  bit         data_moved;
  bit         dbl_strobe;
  vec_t       tbl[6];

  uart_rx_deserializer #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR    (DVSR),
    .DVSR_W  (3)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (!stop) begin
      repeat (hold_bits) drive_bit(1'b0);
      drive_bit(1'b1);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic ferr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout: got %0d strobes pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      rst_q = i_reset;
      @(negedge clk);
      if (armed) begin
        if (!rst_q) model_data = 8'h00;
        if (o_rx_done === 1'b1) begin
          if (prev_done) dbl_strobe = 1'b1;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_strobe: got data=%h ferr=%b, expected no strobe", o_data, o_frame_err);
          end else begin
            e = exp_q.pop_front();
            model_data = e.data;
            if (o_data !== e.data || o_frame_err !== e.ferr) begin
              miscompares++;
              $display("FAIL rx_byte: got data=%h ferr=%b, expected data=%h ferr=%b",
                       o_data, o_frame_err, e.data, e.ferr);
            end
          end
        end else begin
          if (o_frame_err !== 1'b0) ferr_leak = 1'b1;
          if (o_data !== model_data) data_moved = 1'b1;
        end
        prev_done = (o_rx_done === 1'b1);
      end
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    int  gap;
    logic [7:0] rd;
    logic rs;
    vectors     = 0;
    miscompares = 0;
    model_data  = 8'h00;
    rst_q       = 1'b0;
    armed       = 1'b0;
    ferr_leak   = 1'b0;
    data_moved  = 1'b0;
    dbl_strobe  = 1'b0;
    i_reset     = 1'b0;
    i_rx        = 1'b1;

    tbl[0] = '{8'h00, 1'b1, 0,  30, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 0,  0,  8'hFF, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 40, 64, 8'h3C, 1'b1};
    tbl[3] = '{8'h12, 1'b1, 0,  10, 8'h12, 1'b0};
    tbl[4] = '{8'h81, 1'b1, 0,  5,  8'h81, 1'b0};
    tbl[5] = '{8'h7E, 1'b0, 0,  20, 8'h7E, 1'b1};

    fork
      monitor();
    join_none

    // Reset state.
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("reset_data", {24'd0, o_data}, 32'h0);
    check("reset_rx_done", {31'd0, o_rx_done}, 32'h0);
    check("reset_frame_err", {31'd0, o_frame_err}, 32'h0);
    check("reset_busy", {31'd0, o_busy}, 32'h0);
    armed = 1'b1;

    // 0xA5 with strobe latency and width measured from the start edge.
    repeat (3) @(negedge clk);
    expect_byte(8'hA5, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
          @(posedge clk);
          cyc++;
          @(negedge clk);
          if (o_rx_done === 1'b1) seen = 1'b1;
        end
        check("strobe_latency_in_window",
              {31'd0, (seen && cyc >= LAT_LO && cyc <= LAT_HI)}, 32'h1);
        @(negedge clk);
        check("rx_done_one_clock", {31'd0, o_rx_done}, 32'h0);
      end
    join
    wait_drain(200);
    repeat (BIT_CLKS) @(negedge clk);
    check("busy_after_a5", {31'd0, o_busy}, 32'h0);

    // Table of single frames, including a framing error followed by a break.
    for (int v = 0; v < 6; v++) begin
      expect_byte(tbl[v].exp_data, tbl[v].exp_ferr);
      send_frame(tbl[v].data, tbl[v].stop, tbl[v].hold);
      i_rx = 1'b1;
      repeat (tbl[v].gap) @(negedge clk);
      wait_drain(200);
    end
    repeat (BIT_CLKS) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hFF, 1'b0);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    wait_drain(200);
    repeat (BIT_CLKS) @(negedge clk);

    // Start-bit glitch of 5 ticks: no strobe, back to IDLE, data held.
    i_rx = 1'b0;
    repeat (5 * DVSR) @(negedge clk);
    i_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_busy", {31'd0, o_busy}, 32'h0);
    check("glitch_data_held", {24'd0, o_data}, {24'd0, model_data});

    // Reset pulse during data bit 4 of 0x5A, then a clean 0x77.
    rd = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    i_rx = rd[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("busy_mid_frame", {31'd0, o_busy}, 32'h1);
    i_reset = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    check("busy_after_reset", {31'd0, o_busy}, 32'h0);
    i_rx = 1'b1;
    repeat (10 * BIT_CLKS) @(negedge clk);
    check("data_after_reset", {24'd0, o_data}, 32'h0);
    expect_byte(8'h77, 1'b0);
    send_frame(8'h77, 1'b1, 0);
    wait_drain(200);

    // Randomized frames: random bytes, occasional low stop bit, random gaps.
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      expect_byte(rd, ~rs);
      send_frame(rd, rs, int'($urandom_range(0, 3)));
      gap = int'($urandom_range(0, 100));
      i_rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    wait_drain(2000);
    repeat (BIT_CLKS) @(negedge clk);
    check("busy_end", {31'd0, o_busy}, 32'h0);

    // Sticky properties gathered by the monitor over the whole run.
    check("frame_err_zero_without_strobe", {31'd0, ferr_leak}, 32'h0);
    check("data_stable_between_strobes", {31'd0, data_moved}, 32'h0);
    check("no_double_wide_strobe", {31'd0, dbl_strobe}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
